// File: rtl/sdram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_arbiter: three toggle-handshake requesters sharing one SDRAM controller
// Rev 1.0
// ---------------------------------------------------------------------------
module sdram_arbiter #(
  parameter int P0_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_req,
  output logic        p0_ack,
  input  logic        p0_we,
  input  logic [1:0]  p0_wm,
  input  logic [21:0] p0_address,
  input  logic [15:0] p0_data_write,
  output logic [15:0] p0_data_read,
  input  logic        p1_req,
  output logic        p1_ack,
  input  logic        p1_we,
  input  logic [1:0]  p1_wm,
  input  logic [21:0] p1_address,
  input  logic [15:0] p1_data_write,
  output logic [15:0] p1_data_read,
  input  logic        p2_req,
  output logic        p2_ack,
  input  logic        p2_we,
  input  logic [1:0]  p2_wm,
  input  logic [21:0] p2_address,
  input  logic [15:0] p2_data_write,
  output logic [15:0] p2_data_read,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        mem_we,
  output logic [1:0]  mem_wm,
  output logic [21:0] mem_address,
  output logic [15:0] mem_data_write,
  input  logic [15:0] mem_data_read,
  output logic [1:0]  grant,
  output logic        busy
);

  localparam logic [3:0] BURST = 4'(P0_BURST);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state, state_next;

  logic [2:0]  req_in, we_in, ack_q, pending;
  logic [1:0]  wm_in    [3];
  logic [21:0] addr_in  [3];
  logic [15:0] wdata_in [3];
  logic [15:0] rdata_q  [3];

  logic        others, issue, complete, rr_ptr;
  logic [1:0]  sel;
  logic [3:0]  p0_cnt;
  logic        sel_we;
  logic [1:0]  sel_wm;
  logic [21:0] sel_addr;
  logic [15:0] sel_wdata;

  assign req_in      = {p2_req, p1_req, p0_req};
  assign we_in       = {p2_we, p1_we, p0_we};
  assign wm_in[0]    = p0_wm;
  assign wm_in[1]    = p1_wm;
  assign wm_in[2]    = p2_wm;
  assign addr_in[0]  = p0_address;
  assign addr_in[1]  = p1_address;
  assign addr_in[2]  = p2_address;
  assign wdata_in[0] = p0_data_write;
  assign wdata_in[1] = p1_data_write;
  assign wdata_in[2] = p2_data_write;

  assign p0_ack       = ack_q[0];
  assign p1_ack       = ack_q[1];
  assign p2_ack       = ack_q[2];
  assign p0_data_read = rdata_q[0];
  assign p1_data_read = rdata_q[1];
  assign p2_data_read = rdata_q[2];

  assign pending = req_in ^ ack_q;
  assign others  = pending[1] | pending[2];
  assign busy    = (state == WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // rr_ptr low prefers port 1, high prefers port 2
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    complete   = 1'b0;
    if (pending[0] && !((p0_cnt >= BURST) && others))
      sel = 2'd0;
    else if (pending[1] && (!pending[2] || !rr_ptr))
      sel = 2'd1;
    else
      sel = 2'd2;
    case (state)
      IDLE: if ((|pending) && (mem_req == mem_ack)) begin
        issue      = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (mem_ack == mem_req) begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = we_in[2];
    sel_wm    = wm_in[2];
    sel_addr  = addr_in[2];
    sel_wdata = wdata_in[2];
    case (sel)
      2'd0: begin
        sel_we    = we_in[0];
        sel_wm    = wm_in[0];
        sel_addr  = addr_in[0];
        sel_wdata = wdata_in[0];
      end
      2'd1: begin
        sel_we    = we_in[1];
        sel_wm    = wm_in[1];
        sel_addr  = addr_in[1];
        sel_wdata = wdata_in[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_wm         <= 2'b11;
      mem_address    <= '0;
      mem_data_write <= '0;
      ack_q          <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
      grant          <= 2'd3;
      rr_ptr         <= 1'b0;
      p0_cnt         <= '0;
    end else begin
      if (issue) begin
        mem_req        <= ~mem_req;
        mem_we         <= sel_we;
        mem_wm         <= sel_wm;
        mem_address    <= sel_addr;
        mem_data_write <= sel_wdata;
        grant          <= sel;
      end
      if (complete) begin
        grant <= 2'd3;
        for (int i = 0; i < 3; i++) begin
          if (grant == 2'(i)) begin
            ack_q[i]   <= ~ack_q[i];
            rdata_q[i] <= mem_data_read;
          end
        end
        if (grant != 2'd0) rr_ptr <= (grant == 2'd1);
      end
      // Burst counter only matters while port 1 or 2 is competing
      if (!others)
        p0_cnt <= '0;
      else if (issue)
        p0_cnt <= (sel != 2'd0) ? 4'd0 : ((p0_cnt < BURST) ? 4'(p0_cnt + 4'd1) : p0_cnt);
    end
  end

endmodule
`default_nettype wire
